// File: rtl/regfile_clr_bypass.sv
// Register file with a sequential bulk clear, an optional hard-wired zero
// register at the top address, and optional same-cycle write-to-read forwarding.
module regfile_clr_bypass #(
    parameter int WIDTH    = 64,
    parameter int AWIDTH   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              ResetL,
    input  logic [AWIDTH-1:0] RA,
    input  logic [AWIDTH-1:0] RB,
    input  logic [AWIDTH-1:0] RW,
    input  logic [WIDTH-1:0]  BusW,
    input  logic              RegWr,
    input  logic              ClrReq,
    output logic [WIDTH-1:0]  BusA,
    output logic [WIDTH-1:0]  BusB,
    output logic              Ready
);

    localparam int DEPTH = 32'd1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic              wr_commit_s;

    // A write commits only in RUN, without a competing clear, and never to XZR.
    always_comb begin
        wr_commit_s = 1'b0;
        if ((state_q == ST_RUN) && RegWr && !ClrReq &&
            !((ZERO_REG != 0) && (RW == LAST_ADDR))) begin
            wr_commit_s = 1'b1;
        end else begin
            wr_commit_s = 1'b0;
        end
    end

    // State register: synchronous reset restarts the clear from address 0.
    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: the clear walks every address once, then hands over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
            ST_RUN: begin
                if (ClrReq) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage update: clear writes take the port while clearing, else the committed write.
    always_comb begin
        regs_d = regs_q;
        if (ResetL && (state_q == ST_CLEAR)) begin
            regs_d[cnt_q] = '0;
        end else if (ResetL && wr_commit_s) begin
            regs_d[RW] = BusW;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage array: contents are defined only by the clear, so no reset here.
    always_ff @(posedge Clk) begin
        regs_q <= regs_d;
    end

    // Outputs: reads are forced to 0 outside RUN and at XZR, then forwarded or stored.
    always_comb begin
        Ready = (state_q == ST_RUN);
        BusA  = '0;
        BusB  = '0;
        if (state_q == ST_RUN) begin
            if ((ZERO_REG != 0) && (RA == LAST_ADDR)) begin
                BusA = '0;
            end else if ((BYPASS != 0) && wr_commit_s && (RA == RW)) begin
                BusA = BusW;
            end else begin
                BusA = regs_q[RA];
            end
            if ((ZERO_REG != 0) && (RB == LAST_ADDR)) begin
                BusB = '0;
            end else if ((BYPASS != 0) && wr_commit_s && (RB == RW)) begin
                BusB = BusW;
            end else begin
                BusB = regs_q[RB];
            end
        end else begin
            BusA = '0;
            BusB = '0;
        end
    end

endmodule

// File: doc/regfile_clr_bypass.md
REGFILE_CLR_BYPASS -- requirements
Module: regfile_clr_bypass

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64: register and bus width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 5: address width, with DEPTH = 2**AWIDTH registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1: when 1, register DEPTH-1 is the hard-wired zero register (XZR).
REQ-004 The block SHALL have parameter BYPASS, default 1: when 1, same-cycle write-to-read forwarding is enabled.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port ResetL, input, 1 bit: synchronous active-low reset, sampled on the rising edge of Clk.
REQ-007 The block SHALL have ports RA and RB, input, AWIDTH bits each: read addresses for ports A and B.
REQ-008 The block SHALL have port RW, input, AWIDTH bits: write address.
REQ-009 The block SHALL have port BusW, input, WIDTH bits: write data.
REQ-010 The block SHALL have port RegWr, input, 1 bit: write enable.
REQ-011 The block SHALL have port ClrReq, input, 1 bit: request to bulk-clear all registers.
REQ-012 The block SHALL have ports BusA and BusB, output, WIDTH bits each: combinational read data.
REQ-013 The block SHALL have port Ready, output, 1 bit: high when in RUN state.

Function
REQ-014 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 In CLEAR, the block SHALL write 0 to regs[Cnt] each cycle, increment Cnt, and enter RUN on the edge where Cnt == DEPTH-1 is written.
REQ-016 A full clear SHALL take exactly DEPTH cycles, and Ready SHALL rise on the edge after the final clear write.
REQ-017 In CLEAR, the block SHALL ignore RegWr and ClrReq, and BusA and BusB SHALL read 0.
REQ-018 In RUN, RegWr=1 SHALL write BusW to regs[RW] on the rising edge, except when ZERO_REG=1 and RW == DEPTH-1, in which case the write SHALL be dropped.
REQ-019 In RUN, ClrReq=1 SHALL move the FSM to CLEAR with Cnt=0 on the next edge; a write asserted in the same cycle SHALL be dropped (clear has priority).
REQ-020 Reads SHALL be combinational with zero latency: BusA = regs[RA] and BusB = regs[RB].
REQ-021 When ZERO_REG=1, a read at address DEPTH-1 SHALL return 0 regardless of any stored or forwarded data.
REQ-022 When BYPASS=1 and the cycle carries a committing write (RUN, RegWr=1, no ClrReq, RW not the zero register), reads of RA == RW and/or RB == RW SHALL return BusW in the same cycle.
REQ-023 When BYPASS=0, a read of an address being written SHALL return the old value until after the edge.
REQ-024 Cnt SHALL be AWIDTH bits wide and SHALL NOT wrap into a second pass; the FSM leaves CLEAR at DEPTH-1.

Reset
REQ-025 On ResetL=0 at a rising edge, the block SHALL set FSM=CLEAR, Cnt=0 and Ready=0, overriding all other inputs.
REQ-026 Reset asserted mid-clear or mid-operation SHALL restart the clear from Cnt=0.
REQ-027 Register contents are undefined until the first clear completes; while Ready=0, outputs BusA and BusB SHALL be 0.

Verification
REQ-028 Reset scenario: hold ResetL=0 for 2 cycles, then release -> Ready=0 for exactly 32 cycles, then Ready=1, and every address reads 0.
REQ-029 Write/read scenario: RegWr=1, RW=5, BusW=0xDEADBEEF_00000001 -> after the edge, RA=5 returns the value; RB=31 returns 0.
REQ-030 Bypass scenario: with BYPASS=1, RegWr=1, RW=RA=RB=7, BusW=0x1234 -> BusA=BusB=0x1234 in the same cycle; with BYPASS=0 -> BusA=BusB=old value (0).
REQ-031 XZR scenario: RegWr=1, RW=31, BusW=all-ones -> RA=31 reads 0, both in the same cycle and afterwards.
REQ-032 Clear-priority scenario: in RUN, ClrReq=1 with RegWr=1, RW=3, BusW=0xAA -> Ready=0 next cycle, no write occurs, regs[3]=0 after 32 cycles, and Ready=1.
REQ-033 Reset mid-clear scenario: ResetL=0 at Cnt=10 -> after release, Ready stays low for a full 32 cycles again.
